// File: rtl/mesi_isc_breq_arb_n.sv
// Broadcast-request front end for the MESI intersection controller: per-CPU request FIFOs with
// one-cycle acks, round-robin arbitration and a tagged write into the downstream broadcast FIFO.
module mesi_isc_breq_arb_n #(
  parameter int unsigned NUM_CPUS            = 4,
  parameter int unsigned CPU_ID_WIDTH        = 2,
  parameter int unsigned ADDR_WIDTH          = 32,
  parameter int unsigned MBUS_CMD_WIDTH      = 3,
  parameter int unsigned BROAD_TYPE_WIDTH    = 2,
  parameter int unsigned BROAD_ID_WIDTH      = 5,
  parameter int unsigned BREQ_FIFO_SIZE      = 2,
  parameter int unsigned BREQ_FIFO_SIZE_LOG2 = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CPUS*MBUS_CMD_WIDTH-1:0] mbus_cmd_array_i,
  input  logic [NUM_CPUS*ADDR_WIDTH-1:0]     mbus_addr_array_i,
  output logic [NUM_CPUS-1:0]                mbus_ack_array_o,
  input  logic                               broad_fifo_full_i,
  output logic                               broad_fifo_wr_o,
  output logic [BROAD_TYPE_WIDTH-1:0]        broad_type_o,
  output logic [ADDR_WIDTH-1:0]              broad_addr_o,
  output logic [CPU_ID_WIDTH-1:0]            broad_cpu_id_o,
  output logic [BROAD_ID_WIDTH-1:0]          broad_id_o
);

  localparam logic [MBUS_CMD_WIDTH-1:0]   CmdWrBroad = MBUS_CMD_WIDTH'(3);
  localparam logic [MBUS_CMD_WIDTH-1:0]   CmdRdBroad = MBUS_CMD_WIDTH'(4);
  localparam logic [BROAD_TYPE_WIDTH-1:0] BreqTypeWr = BROAD_TYPE_WIDTH'(1);
  localparam logic [BROAD_TYPE_WIDTH-1:0] BreqTypeRd = BROAD_TYPE_WIDTH'(2);
  localparam int unsigned EntryW = BROAD_TYPE_WIDTH + ADDR_WIDTH;
  localparam int unsigned PtrW   = (BREQ_FIFO_SIZE_LOG2 > 0) ? BREQ_FIFO_SIZE_LOG2 : 1;
  localparam int unsigned CntW   = PtrW + 1;

  logic [EntryW-1:0]           mem_q [NUM_CPUS][BREQ_FIFO_SIZE];
  logic [PtrW-1:0]             wr_ptr_q [NUM_CPUS];
  logic [PtrW-1:0]             wr_ptr_d [NUM_CPUS];
  logic [PtrW-1:0]             rd_ptr_q [NUM_CPUS];
  logic [PtrW-1:0]             rd_ptr_d [NUM_CPUS];
  logic [CntW-1:0]             cnt_q [NUM_CPUS];
  logic [CntW-1:0]             cnt_d [NUM_CPUS];
  logic [EntryW-1:0]           push_entry [NUM_CPUS];
  logic [NUM_CPUS-1:0]         push, pop, ack_q;
  logic [CPU_ID_WIDTH-1:0]     rr_q, rr_d, winner, win_hi, win_lo;
  logic                        found_hi, found_lo, grant;
  logic [EntryW-1:0]           head;
  logic [BROAD_ID_WIDTH-1:0]   tag_q, tag_d, id_q;
  logic                        wr_q;
  logic [BROAD_TYPE_WIDTH-1:0] type_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [CPU_ID_WIDTH-1:0]     cpu_id_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BREQ_FIFO_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  // Capture: a raised ack blocks the same held command from being queued twice.
  always_comb begin
    push = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      logic is_wr, is_rd;
      is_wr = (mbus_cmd_array_i[i*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH] == CmdWrBroad);
      is_rd = (mbus_cmd_array_i[i*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH] == CmdRdBroad);
      push[i] = (is_wr || is_rd) && (cnt_q[i] < CntW'(BREQ_FIFO_SIZE)) && !ack_q[i];
      push_entry[i] = {is_wr ? BreqTypeWr : BreqTypeRd,
                       mbus_addr_array_i[i*ADDR_WIDTH +: ADDR_WIDTH]};
    end
  end

  // Round-robin: lowest non-empty index at or above rr_q wins, else lowest below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = NUM_CPUS - 1; i >= 0; i--) begin
      if (cnt_q[i] != '0) begin
        if (CPU_ID_WIDTH'(i) >= rr_q) begin
          found_hi = 1'b1;
          win_hi   = CPU_ID_WIDTH'(i);
        end else begin
          found_lo = 1'b1;
          win_lo   = CPU_ID_WIDTH'(i);
        end
      end
    end
    winner = found_hi ? win_hi : win_lo;
    grant  = (found_hi || found_lo) && !broad_fifo_full_i;
    pop    = '0;
    head   = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      if (grant && (winner == CPU_ID_WIDTH'(i))) begin
        pop[i] = 1'b1;
        head   = mem_q[i][rd_ptr_q[i]];
      end
    end
    rr_d  = rr_q;
    tag_d = tag_q;
    if (grant) begin
      rr_d  = (winner == CPU_ID_WIDTH'(NUM_CPUS - 1)) ? '0 : winner + 1'b1;
      tag_d = tag_q + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CPUS; i++) begin
      wr_ptr_d[i] = push[i] ? ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
      rd_ptr_d[i] = pop[i] ? ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      if (push[i] && !pop[i]) cnt_d[i] = cnt_q[i] + 1'b1;
      if (!push[i] && pop[i]) cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CPUS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      ack_q    <= '0;
      rr_q     <= '0;
      tag_q    <= '0;
      wr_q     <= 1'b0;
      type_q   <= '0;
      addr_q   <= '0;
      cpu_id_q <= '0;
      id_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_CPUS; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      ack_q <= push;
      rr_q  <= rr_d;
      tag_q <= tag_d;
      wr_q  <= grant;
      if (grant) begin
        {type_q, addr_q} <= head;
        cpu_id_q         <= winner;
        id_q             <= tag_q;
      end
    end
  end

  // Storage needs no reset: pointers and counts define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CPUS; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= push_entry[i];
    end
  end

  assign mbus_ack_array_o = ack_q;
  assign broad_fifo_wr_o  = wr_q;
  assign broad_type_o     = type_q;
  assign broad_addr_o     = addr_q;
  assign broad_cpu_id_o   = cpu_id_q;
  assign broad_id_o       = id_q;

endmodule

// File: tb/tb_mesi_isc_breq_arb_n.sv
// Bench for mesi_isc_breq_arb_n: directed scenarios plus randomized traffic against a
// queue-based reference model advanced in lockstep with the clock.
module tb_mesi_isc_breq_arb_n;
  localparam int NCPU = 4;

  typedef struct packed {
    logic [1:0]  typ;
    logic [31:0] addr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        full;
  logic [2:0]  cmd [NCPU];
  logic [31:0] addr [NCPU];
  logic [NCPU*3-1:0]  cmd_arr;
  logic [NCPU*32-1:0] addr_arr;
  logic [3:0]  ack;
  logic        wr;
  logic [1:0]  btype;
  logic [31:0] baddr;
  logic [1:0]  bcpu;
  logic [4:0]  bid;

  // Reference model state
  ent_t        mq [NCPU][$];
  int          m_rr, m_tag;
  logic [3:0]  m_ack;
  logic        m_wr;
  logic [1:0]  m_type;
  logic [31:0] m_addr;
  logic [1:0]  m_cpu;
  logic [4:0]  m_id;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always_comb begin
    cmd_arr  = '0;
    addr_arr = '0;
    for (int i = 0; i < NCPU; i++) begin
      cmd_arr[i*3 +: 3]   = cmd[i];
      addr_arr[i*32 +: 32] = addr[i];
    end
  end

  mesi_isc_breq_arb_n dut (
    .clk               (clk),
    .rst               (rst),
    .mbus_cmd_array_i  (cmd_arr),
    .mbus_addr_array_i (addr_arr),
    .mbus_ack_array_o  (ack),
    .broad_fifo_full_i (full),
    .broad_fifo_wr_o   (wr),
    .broad_type_o      (btype),
    .broad_addr_o      (baddr),
    .broad_cpu_id_o    (bcpu),
    .broad_id_o        (bid)
  );

  // One edge of the specified behaviour, from the inputs as they stand before the edge.
  task automatic model_update();
    int   sz [NCPU];
    logic [3:0] nack;
    bit   done;
    ent_t e;
    if (rst) begin
      for (int i = 0; i < NCPU; i++) mq[i].delete();
      m_rr = 0; m_tag = 0; m_ack = '0; m_wr = 1'b0;
      m_type = '0; m_addr = '0; m_cpu = '0; m_id = '0;
      return;
    end
    for (int i = 0; i < NCPU; i++) sz[i] = mq[i].size();
    m_wr = 1'b0;
    done = 1'b0;
    if (!full) begin
      for (int k = 0; k < NCPU; k++) begin
        int c;
        c = (m_rr + k) % NCPU;
        if (!done && sz[c] > 0) begin
          e = mq[c].pop_front();
          done = 1'b1;
          m_wr = 1'b1; m_type = e.typ; m_addr = e.addr;
          m_cpu = 2'(c); m_id = 5'(m_tag);
          m_tag = (m_tag + 1) % 32;
          m_rr = (c + 1) % NCPU;
        end
      end
    end
    nack = '0;
    for (int i = 0; i < NCPU; i++) begin
      if ((cmd[i] == 3'd3 || cmd[i] == 3'd4) && sz[i] < 2 && !m_ack[i]) begin
        e.typ = (cmd[i] == 3'd3) ? 2'd1 : 2'd2;
        e.addr = addr[i];
        mq[i].push_back(e);
        nack[i] = 1'b1;
      end
    end
    m_ack = nack;
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < NCPU; i++) begin
      cmd[i] = 3'd0;
      addr[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; full = 1'b0; idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; full = 1'b0; idle_inputs();
    tick(); tick();
    tests++;
    if ({ack, wr, btype, baddr, bcpu, bid} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ack=%b wr=%b type=%0d addr=%h cpu=%0d id=%0d, want all 0",
               ack, wr, btype, baddr, bcpu, bid);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_wr();
    int nack = 0, nwr = 0, ack_cyc = -1, wr_cyc = -1;
    do_reset();
    cmd[2] = 3'd3; addr[2] = 32'h0000_1234;
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick();
      if (ack[2]) begin nack++; ack_cyc = cyc; cmd[2] = 3'd0; end
      if (wr) begin
        nwr++; wr_cyc = cyc;
        tests++;
        if ({btype, baddr, bcpu, bid} !== {2'd1, 32'h1234, 2'd2, 5'd0}) begin
          fails++;
          $display("FAIL single_fields: got type=%0d addr=%h cpu=%0d id=%0d, want 1 1234 2 0",
                   btype, baddr, bcpu, bid);
        end
      end
      if (ack[0] || ack[1] || ack[3]) begin
        tests++; fails++;
        $display("FAIL single_spurious_ack: got %b, want only bit 2", ack);
      end
    end
    tests++;
    if (nack != 1 || ack_cyc != 0) begin
      fails++;
      $display("FAIL single_ack: got %0d acks at cycle %0d, want 1 at cycle 0", nack, ack_cyc);
    end
    tests++;
    if (nwr != 1 || wr_cyc != 1) begin
      fails++;
      $display("FAIL single_wr: got %0d writes at cycle %0d, want 1 at cycle 1", nwr, wr_cyc);
    end
  endtask

  task automatic test_all_rd();
    do_reset();
    for (int i = 0; i < NCPU; i++) begin
      cmd[i] = 3'd4; addr[i] = 32'((i + 1) * 16);
    end
    tick();
    tests++;
    if (ack !== 4'hF) begin
      fails++; $display("FAIL all_rd_ack: got %b, want 1111", ack);
    end
    idle_inputs();
    for (int k = 0; k < NCPU; k++) begin
      tick();
      tests++;
      if ({wr, btype, baddr, bcpu, bid} !== {1'b1, 2'd2, 32'((k + 1) * 16), 2'(k), 5'(k)}) begin
        fails++;
        $display("FAIL all_rd_grant%0d: got wr=%b type=%0d addr=%h cpu=%0d id=%0d", k,
                 wr, btype, baddr, bcpu, bid);
      end
    end
    tick();
    tests++;
    if (wr !== 1'b0) begin
      fails++; $display("FAIL all_rd_drained: got wr=%b, want 0", wr);
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] seq [3];
    logic [31:0] got [$];
    int n = 0, nwr = 0;
    seq[0] = 32'hA0; seq[1] = 32'hA1; seq[2] = 32'hA2;
    do_reset();
    full = 1'b1; cmd[1] = 3'd3; addr[1] = seq[0];
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      if (wr) nwr++;
      if (ack[1]) begin
        n++;
        if (n < 3) addr[1] = seq[n]; else cmd[1] = 3'd0;
      end
    end
    tests++;
    if (n != 2 || nwr != 0) begin
      fails++; $display("FAIL full_hold: got %0d acks %0d writes, want 2 acks 0 writes", n, nwr);
    end
    full = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      if (wr) got.push_back(baddr);
      if (ack[1]) begin n++; cmd[1] = 3'd0; end
    end
    tests++;
    if (n != 3 || got.size() != 3) begin
      fails++; $display("FAIL full_release: got %0d acks %0d writes, want 3 and 3", n, got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (got[k] !== seq[k]) begin
          fails++; $display("FAIL full_order%0d: got addr %h, want %h", k, got[k], seq[k]);
        end
      end
    end
  endtask

  task automatic test_ignored_cmds();
    int ign [6];
    ign[0] = 0; ign[1] = 1; ign[2] = 2; ign[3] = 5; ign[4] = 6; ign[5] = 7;
    do_reset();
    for (int cyc = 0; cyc < 10; cyc++) begin
      cmd[0] = 3'(ign[$urandom_range(0, 5)]);
      addr[0] = $urandom;
      tick();
      tests++;
      if (ack !== 4'b0 || wr !== 1'b0) begin
        fails++; $display("FAIL ignored_cmd: cmd=%0d got ack=%b wr=%b, want 0 0", cmd[0], ack, wr);
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int nack = 0, nwr = 0, order_ok;
    do_reset();
    cmd[3] = 3'd3; addr[3] = 32'd0;
    for (int cyc = 0; cyc < 200 && nwr < 33; cyc++) begin
      tick();
      if (ack[3]) begin
        nack++;
        if (nack >= 33) cmd[3] = 3'd0; else addr[3] = 32'(nack);
      end
      if (wr) begin
        tests++;
        if ({bid, bcpu, baddr} !== {5'(nwr % 32), 2'd3, 32'(nwr)}) begin
          fails++;
          $display("FAIL b2b_write%0d: got id=%0d cpu=%0d addr=%h, want id=%0d cpu=3 addr=%h",
                   nwr, bid, bcpu, baddr, nwr % 32, nwr);
        end
        nwr++;
      end
    end
    tests++;
    if (nwr != 33) begin
      fails++; $display("FAIL b2b_count: got %0d writes, want 33", nwr);
    end
    // After granting CPU3 the pointer wraps to 0, so CPU0 must win a tie with CPU3.
    tick();
    cmd[0] = 3'd4; addr[0] = 32'hC0; cmd[3] = 3'd4; addr[3] = 32'hC3;
    tick();
    idle_inputs();
    order_ok = 1;
    tick();
    if (!(wr === 1'b1 && bcpu === 2'd0 && bid === 5'd1)) order_ok = 0;
    tick();
    if (!(wr === 1'b1 && bcpu === 2'd3 && bid === 5'd2)) order_ok = 0;
    tests++;
    if (order_ok == 0) begin
      fails++; $display("FAIL b2b_rr_wrap: last got wr=%b cpu=%0d id=%0d, want cpu0 then cpu3",
                        wr, bcpu, bid);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0, got_wr = 0;
    do_reset();
    full = 1'b1; cmd[0] = 3'd4; addr[0] = 32'h50;
    for (int cyc = 0; cyc < 10 && n < 2; cyc++) begin
      tick();
      if (ack[0]) begin n++; addr[0] = 32'h51; if (n == 2) cmd[0] = 3'd0; end
    end
    tick();
    rst = 1'b1; full = 1'b0;
    tick();
    tests++;
    if ({ack, wr, btype, baddr, bcpu, bid} !== '0) begin
      fails++; $display("FAIL midreset_outputs: got ack=%b wr=%b addr=%h, want 0", ack, wr, baddr);
    end
    rst = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      tests++;
      if (wr !== 1'b0 || ack !== 4'b0) begin
        fails++; $display("FAIL midreset_flushed: got wr=%b ack=%b, want 0 0", wr, ack);
      end
    end
    cmd[2] = 3'd3; addr[2] = 32'h77;
    for (int cyc = 0; cyc < 8 && got_wr == 0; cyc++) begin
      tick();
      if (ack[2]) cmd[2] = 3'd0;
      if (wr) begin
        got_wr = 1;
        tests++;
        if ({bid, bcpu, baddr} !== {5'd0, 2'd2, 32'h77}) begin
          fails++; $display("FAIL midreset_newid: got id=%0d cpu=%0d addr=%h, want 0 2 77",
                            bid, bcpu, baddr);
        end
      end
    end
    tests++;
    if (got_wr == 0) begin
      fails++; $display("FAIL midreset_timeout: got no write, want one within 8 cycles");
    end
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NCPU; i++) begin
        cmd[i] = 3'($urandom_range(0, 7));
        addr[i] = $urandom;
      end
      full = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
      tests++;
      if (ack !== m_ack || wr !== m_wr) begin
        fails++; $display("FAIL rand_ctl@%0d: got ack=%b wr=%b, want ack=%b wr=%b",
                          cyc, ack, wr, m_ack, m_wr);
      end
      tests++;
      if ({btype, baddr, bcpu, bid} !== {m_type, m_addr, m_cpu, m_id}) begin
        fails++; $display("FAIL rand_data@%0d: got %0d %h %0d %0d, want %0d %h %0d %0d", cyc,
                          btype, baddr, bcpu, bid, m_type, m_addr, m_cpu, m_id);
      end
    end
    rst = 1'b0; full = 1'b0; idle_inputs();
  endtask

  initial begin
    rst = 1'b1; full = 1'b0; idle_inputs();
    test_reset();
    test_single_wr();
    test_all_rd();
    test_fifo_full();
    test_ignored_cmds();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mesi_isc_breq_arb_n.md
Name: mesi_isc_breq_arb_n

Overview:
- Parametrised successor to the fixed 4-CPU broadcast-request front end of the MESI intersection controller.
- Collects WR_BROAD/RD_BROAD requests from NUM_CPUS main-bus ports into per-CPU request FIFOs and acknowledges each request.
- Arbitrates round-robin among non-empty FIFOs and writes one tagged broadcast per cycle into the downstream broadcast FIFO.
- Sits between the CPU main-bus ports and the broadcast queue/coherence-bus controller.

Parameters:
- NUM_CPUS, 4, number of CPU ports (2..16).
- CPU_ID_WIDTH, 2, width of CPU index; must equal ceil(log2(NUM_CPUS)).
- ADDR_WIDTH, 32, main-bus address width.
- MBUS_CMD_WIDTH, 3, main-bus command width.
- BROAD_TYPE_WIDTH, 2, broadcast type width.
- BROAD_ID_WIDTH, 5, broadcast tag width.
- BREQ_FIFO_SIZE, 2, entries per CPU FIFO.
- BREQ_FIFO_SIZE_LOG2, 1, log2 of BREQ_FIFO_SIZE.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mbus_cmd_array_i  in  NUM_CPUS*MBUS_CMD_WIDTH  per-CPU command; CPU i in slice i.
- mbus_addr_array_i  in  NUM_CPUS*ADDR_WIDTH  per-CPU address; CPU i in slice i.
- mbus_ack_array_o  out  NUM_CPUS  per-CPU one-cycle acknowledge.
- broad_fifo_full_i  in  1  downstream broadcast FIFO full.
- broad_fifo_wr_o  out  1  write strobe to the broadcast FIFO.
- broad_type_o  out  BROAD_TYPE_WIDTH  BREQ_TYPE_WR (1) or BREQ_TYPE_RD (2).
- broad_addr_o  out  ADDR_WIDTH  broadcast address.
- broad_cpu_id_o  out  CPU_ID_WIDTH  originating CPU.
- broad_id_o  out  BROAD_ID_WIDTH  sequential broadcast tag.

Behaviour:
- Reset (sync, active-high) clears:
  - all outputs to 0;
  - all FIFO pointers and counts to 0 (all FIFOs empty);
  - the round-robin pointer to 0;
  - the tag counter to 0.
- Reset asserted mid-operation discards every queued request. No ack or write is issued in the reset cycle or the cycle after it.
- Request capture, per CPU i, evaluated at each edge:
  - Push when cmd_i is WR_BROAD (3) or RD_BROAD (4), fifo_i count < BREQ_FIFO_SIZE, and mbus_ack_array_o[i] is currently 0.
  - Pushed entry = {type, addr}, with type = WR (1) for WR_BROAD and RD (2) for RD_BROAD.
  - mbus_ack_array_o[i] goes high for exactly one cycle following the push edge.
  - The ack=1 cycle blocks a re-push, so a command held through the ack cycle is queued only once.
- Commands NOP (0), WR (1), RD (2) and codes 5..7 are ignored: no push, no ack.
- FIFO full: the request is held unacknowledged until space frees. Fullness is evaluated from the pre-pop count, so a push is not accepted in the same edge as a pop that frees the slot.
- Arbitration, at each edge when rst=0 and broad_fifo_full_i=0:
  - Candidates are FIFOs whose pre-push count > 0.
  - Search starts at rr_ptr and goes upward with wrap from NUM_CPUS-1 to 0; the first candidate wins.
  - Pop the winner's head and register broad_fifo_wr_o=1 together with its type, addr, cpu_id and the current tag.
  - Tag counter increments by 1, wrapping modulo 2^BROAD_ID_WIDTH (31 -> 0).
  - rr_ptr becomes winner+1 modulo NUM_CPUS.
- No candidates or broad_fifo_full_i=1: broad_fifo_wr_o=0 next cycle; data outputs hold their last values; rr_ptr and tag are unchanged.
- Latency: command presented before edge t gives ack high in cycle t..t+1 and broad_fifo_wr_o high no earlier than the cycle after edge t+1.
- An entry pushed at edge t is not eligible before edge t+1.
- Simultaneous push and pop on the same FIFO is legal: count is unchanged and the pointers both advance.
- FIFO pointers wrap at BREQ_FIFO_SIZE.
- Order is preserved within each CPU. Across CPUs, order follows round-robin.
- Throughput: at most one broadcast written per cycle.

Test Plan:
- Reset, then CPU2 drives cmd=3 (WR_BROAD), addr=0x0000_1234, held until ack -> exactly one ack on CPU2 cycle after capture; next cycle wr_o=1, type=1, addr=0x1234, cpu_id=2, id=0.
- All 4 CPUs drive RD_BROAD in the same cycle, addrs 0x10/0x20/0x30/0x40 -> 4 acks together; wr_o high 4 consecutive cycles with cpu_id 0,1,2,3, ids 0..3, type=2.
- broad_fifo_full_i=1 while CPU1 issues 3 requests (BREQ_FIFO_SIZE=2) -> 2 acks, third held unacked; release full -> the 2 entries drain in order, then the third is acked and written.
- CPU0 drives cmd=1 (WR) and cmd=0 for 10 cycles -> no ack, wr_o stays 0.
- 33 back-to-back broadcasts from CPU3 -> ids 0..31 then 0; rr_ptr returns to 0 after each grant.
- Assert rst for one cycle with 2 entries queued in CPU0 -> all outputs 0, no writes afterward; a new request gets id=0.
